fixed_divider: RTL

- Iterative signed fixed-point divider: Q = A / B, where A, B and Q share the 13-bit Q9.4 two's-complement format used by `multiplier`.
- It inverts the multiply path and serves the matrix datapath for normalisation and scaling.
- Restoring, radix-2: one quotient bit per clock, with a start/ready/done handshake.

---
 rtl/fixed_divider.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fixed_divider.sv
// Restoring radix-2 signed Q9.4 divider, one quotient bit per clock, start/ready/done handshake.
// Define FIXED_DIVIDER_SATURATE_EN to clamp Q on overflow and divide-by-zero instead of wrapping.
module fixed_divider #(
  parameter int W    = 13,
  parameter int FRAC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         ovf,
  output logic         dbz
);

  // state | meaning
  // IDLE  | waiting for start while ready=1
  // CALC  | one restoring-division step per cycle, W+FRAC steps
  // FIX   | apply signs, detect overflow, stage the result
  // ZERO  | divisor was zero, stage the dbz result
  // DONE  | publish staged result; done/ready are registered, so the pulse lands next cycle
  typedef enum logic [2:0] {IDLE, CALC, FIX, ZERO, DONE} state_t;

  localparam int NW = W + FRAC;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] MAG_POS = NW'((1 << (W - 1)) - 1);
  localparam logic [NW-1:0] MAG_NEG = NW'(1 << (W - 1));

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_lat;
  logic [W-1:0]  bmag;
  logic [W-1:0]  rem;
  logic [NW-1:0] num;
  logic [NW-1:0] quo;
  logic          sign_q;
  logic          ovf_n;
  logic          dbz_n;

  logic [W-1:0]  amag_in;
  logic [W-1:0]  bmag_in;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  diff;
  logic          ovf_c;
  logic [W-1:0]  q_low;
  logic [W-1:0]  q_fix;
  logic [W-1:0]  q_dbz;
  logic [W-1:0]  r_fix;

  assign amag_in = A[W-1] ? (~A + W'(1)) : A;
  assign bmag_in = B[W-1] ? (~B + W'(1)) : B;

  assign trial = {rem, num[NW-1]};
  assign ge    = (trial >= {1'b0, bmag});
  // when ge holds the true difference is below |B|, so W bits are enough
  assign diff  = trial[W-1:0] - bmag;

  assign ovf_c = sign_q ? (quo > MAG_NEG) : (quo > MAG_POS);
  assign q_low = sign_q ? (~quo[W-1:0] + W'(1)) : quo[W-1:0];
  assign r_fix = a_lat[W-1] ? (~rem + W'(1)) : rem;

`ifdef FIXED_DIVIDER_SATURATE_EN
  localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};
  assign q_fix = ovf_c ? (sign_q ? Q_MIN : Q_MAX) : q_low;
  assign q_dbz = a_lat[W-1] ? Q_MIN : Q_MAX;
`else
  assign q_fix = q_low;
  assign q_dbz = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
      cnt    <= '0;
      a_lat  <= '0;
      bmag   <= '0;
      rem    <= '0;
      num    <= '0;
      quo    <= '0;
      sign_q <= 1'b0;
      ovf_n  <= 1'b0;
      dbz_n  <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (done) ready <= 1'b1;
      case (state)
        IDLE: begin
          if (start && ready) begin
            ready  <= 1'b0;
            a_lat  <= A;
            bmag   <= bmag_in;
            sign_q <= A[W-1] ^ B[W-1];
            num    <= {amag_in, {FRAC{1'b0}}};
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            state  <= (B == '0) ? ZERO : CALC;
          end
        end
        CALC: begin
          rem <= ge ? diff : trial[W-1:0];
          quo <= {quo[NW-2:0], ge};
          num <= {num[NW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NW - 1)) state <= FIX;
        end
        FIX: begin
          quo   <= {{FRAC{1'b0}}, q_fix};
          rem   <= r_fix;
          ovf_n <= ovf_c;
          dbz_n <= 1'b0;
          state <= DONE;
        end
        ZERO: begin
          quo   <= {{FRAC{1'b0}}, q_dbz};
          rem   <= a_lat;
          ovf_n <= 1'b0;
          dbz_n <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          Q     <= quo[W-1:0];
          R     <= rem;
          ovf   <= ovf_n;
          dbz   <= dbz_n;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
